best_time_keeper: RTL and testbench
===================================

Name: best_time_keeper

Overview:
- Sits directly downstream of the stopwatch.
- Watches the stopwatch's game_state flag and, at the end of each run, latches the six frozen BCD time digits as "last time".
- Compares the last time against a held best (smallest) time, updates the best and pulses new_record when beaten, and counts completed runs.
- Feeds the display stage either last or best time through a selectable digit bus.

Parameters:
- SYNC_STAGES, 2, number of flops synchronising game_state (it is produced in the 10 Hz domain) into clk.
- RUN_CNT_W, 8, width of the saturating completed-run counter.

Ports:
- clk  input  1  system clock, same clock as the stopwatch digit counters.
- rst  input  1  asynchronous, active-low reset (low = reset).
- game_state  input  1  stopwatch run flag; high while timing.
- small_sec0, small_sec1, sec0, sec1, min0, min1  input  4 each  stopwatch BCD digits.
- clear_best  input  1  one-cycle synchronous request to forget the best time.
- disp_sel  input  1  0 = drive disp_* from last time, 1 = from best time.
- last_time  output  24  {min1,min0,sec1,sec0,small_sec1,small_sec0} of the last accepted run.
- best_time  output  24  same packing; best accepted run.
- best_valid  output  1  a best time is held.
- new_record  output  1  one-cycle pulse when best_time is replaced by a run.
- bcd_error  output  1  sticky: a run ended with illegal digits.
- run_count  output  RUN_CNT_W  accepted runs, saturating.
- disp_time  output  24  mux of last_time/best_time per disp_sel (combinational).

Behaviour:
- Reset (rst low, async): all registered outputs 0; sync chain 0; FSM to S_IDLE.
- game_state passes through SYNC_STAGES flops; gs_s is the synchronised value, gs_q is gs_s delayed one cycle.
- FSM states and transitions:
  - S_IDLE → S_RUN when gs_s = 1.
  - S_RUN → S_CAPT on a fall (gs_q = 1, gs_s = 0).
  - S_CAPT → S_CMP after 1 cycle.
  - S_CMP → S_IDLE after 1 cycle.
- S_CAPT entry edge:
  - Pack the digits into a 24-bit cap value.
  - Validate: every digit ≤ 9, sec1 ≤ 5, min1 ≤ 5, and the value is non-zero.
  - If valid: last_time ← cap; run_count += 1, saturating at all-ones.
  - If invalid: last_time and run_count unchanged; set bcd_error only for an illegal digit. A zero time is ignored silently.
- S_CMP edge, valid run only:
  - If !best_valid or cap < best_time (unsigned compare of the packed BCD value, which is equivalent to time order): best_time ← cap, best_valid ← 1, new_record high for exactly this one cycle.
  - Equal times do not replace the best and do not pulse new_record.
- Latency: last_time updates on the clk edge that is SYNC_STAGES+1 edges after the first edge that samples game_state low. best_time and new_record update one edge later.
- clear_best: best_time ← 0, best_valid ← 0 in any state. If it coincides with the S_CMP update, clear wins and new_record stays 0. last_time, run_count and bcd_error are unaffected.
- bcd_error clears only on reset.
- A game_state pulse shorter than the sync resolution may be missed; this is accepted.
- A new rise seen during S_CAPT/S_CMP is handled after S_IDLE is re-entered, since gs_s is still high.
- Reset mid-run discards everything.

Decomposition:
- Shared package: BCD_BIT_WIDTH = 4, TIME_W = 24, FSM state enum, and a pack-order constant for digit positions.
- One natural sub-module: sync_edge (SYNC_STAGES synchroniser plus rise/fall pulse outputs), reusable by the keypad and button paths.

Test Plan:
1. Reset: hold rst low with random inputs → every output 0. Release → outputs stay 0 while game_state stays 0.
2. First run: game_state 0→1→0 with digits 01:23.45 → last_time = 24'h012345 at the computed latency; next edge best_time = 24'h012345, best_valid = 1, new_record pulses 1 cycle, run_count = 1.
3. Slower then faster: run 02:00.00 → last_time = 24'h020000, best unchanged, no pulse, run_count = 2. Then run 00:59.99 → best_time = 24'h005999, new_record pulses, run_count = 3.
4. Equal time: repeat 00:59.99 → no new_record, best unchanged.
5. Clear collision: run 00:10.00 with clear_best asserted exactly in the S_CMP cycle → last_time = 24'h001000, best_valid = 0, best_time = 0, new_record = 0.
6. Invalid ends:
   - Run ending with sec1 = 6 → bcd_error = 1, last_time and run_count unchanged.
   - Run ending at 00:00.00 → ignored, bcd_error unchanged.
   - run_count forced to 255 (RUN_CNT_W = 8) then one valid run → stays 255.

Source files
------------

// File: rtl/best_time_keeper_pkg.sv
// Shared types and constants for the best-time keeper.
// Digit packing (MSB..LSB): {min1, min0, sec1, sec0, small_sec1, small_sec0}.
`timescale 1ns/1ps
package best_time_keeper_pkg;

    localparam int unsigned BCD_BIT_WIDTH = 4;
    localparam int unsigned NUM_DIGITS    = 6;
    localparam int unsigned TIME_W        = 24;

    // Digit positions inside the packed time, counted from the LSB digit.
    localparam int unsigned POS_SMALL_SEC0 = 0;
    localparam int unsigned POS_SMALL_SEC1 = 1;
    localparam int unsigned POS_SEC0       = 2;
    localparam int unsigned POS_SEC1       = 3;
    localparam int unsigned POS_MIN0       = 4;
    localparam int unsigned POS_MIN1       = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_CAPT = 2'd2,
        S_CMP  = 2'd3
    } state_e;

    // Every digit is a decimal digit and both tens-of digits are at most 5.
    function automatic logic digits_legal(input logic [TIME_W-1:0] t);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (t[i*BCD_BIT_WIDTH +: BCD_BIT_WIDTH] > 4'd9) ok = 1'b0;
        end
        if (t[POS_SEC1*BCD_BIT_WIDTH +: BCD_BIT_WIDTH] > 4'd5) ok = 1'b0;
        if (t[POS_MIN1*BCD_BIT_WIDTH +: BCD_BIT_WIDTH] > 4'd5) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/best_time_keeper_if.sv
// Bus between the stopwatch/display side (master) and the keeper (slave).
//   master drives: game_state, six BCD digits, clear_best, disp_sel
//   slave drives : last_time, best_time, best_valid, new_record,
//                  bcd_error, run_count, disp_time
`timescale 1ns/1ps
interface best_time_keeper_if #(
    parameter int unsigned RUN_CNT_W = 8
);
    import best_time_keeper_pkg::*;

    logic                      game_state;
    logic [BCD_BIT_WIDTH-1:0]  small_sec0;
    logic [BCD_BIT_WIDTH-1:0]  small_sec1;
    logic [BCD_BIT_WIDTH-1:0]  sec0;
    logic [BCD_BIT_WIDTH-1:0]  sec1;
    logic [BCD_BIT_WIDTH-1:0]  min0;
    logic [BCD_BIT_WIDTH-1:0]  min1;
    logic                      clear_best;
    logic                      disp_sel;

    logic [TIME_W-1:0]         last_time;
    logic [TIME_W-1:0]         best_time;
    logic                      best_valid;
    logic                      new_record;
    logic                      bcd_error;
    logic [RUN_CNT_W-1:0]      run_count;
    logic [TIME_W-1:0]         disp_time;

    modport master (
        output game_state, small_sec0, small_sec1, sec0, sec1, min0, min1,
               clear_best, disp_sel,
        input  last_time, best_time, best_valid, new_record, bcd_error,
               run_count, disp_time
    );

    modport slave (
        input  game_state, small_sec0, small_sec1, sec0, sec1, min0, min1,
               clear_best, disp_sel,
        output last_time, best_time, best_valid, new_record, bcd_error,
               run_count, disp_time
    );

endinterface

// File: rtl/best_time_keeper_sync_edge.sv
// Multi-flop synchroniser with registered rise/fall pulses.
//   clk, rst     : clock, async active-low reset
//   d_i          : asynchronous level
//   level_o      : synchronised level (last chain flop)
//   rise_o/fall_o: one-cycle pulses, one cycle after level_o changes
// STAGES must be at least 2.
`timescale 1ns/1ps
module best_time_keeper_sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              dly_q;
    logic              rise_q;
    logic              fall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            dly_q  <= sync_q[STAGES-1];
            rise_q <=  sync_q[STAGES-1] & ~dly_q;
            fall_q <= ~sync_q[STAGES-1] &  dly_q;
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/best_time_keeper.sv
// Latches the stopwatch time at the end of each run, tracks the best
// (smallest) time, pulses new_record on improvement and counts runs.
//   clk, rst : clock, async active-low reset
//   bus      : slave side of best_time_keeper_if (inputs from the
//              stopwatch, results and display mux back out)
`timescale 1ns/1ps
module best_time_keeper
    import best_time_keeper_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RUN_CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    best_time_keeper_if.slave bus
);

    state_e               state_q;
    logic [TIME_W-1:0]    last_time_q;
    logic [TIME_W-1:0]    best_time_q;
    logic                 best_valid_q;
    logic                 new_record_q;
    logic                 bcd_error_q;
    logic [RUN_CNT_W-1:0] run_count_q;
    logic [TIME_W-1:0]    cap_q;
    logic                 cap_ok_q;

    logic                 gs_s;
    logic                 gs_fall;
    logic                 gs_rise_unused;

    logic [TIME_W-1:0]    cap_d;
    logic                 legal_d;
    logic                 cap_ok_d;
    logic                 beats_best_d;

    // game_state comes from the slow stopwatch domain.
    best_time_keeper_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_gs_sync (
        .clk     (clk),
        .rst     (rst),
        .d_i     (bus.game_state),
        .level_o (gs_s),
        .rise_o  (gs_rise_unused),
        .fall_o  (gs_fall)
    );

    // Candidate time and its validity, evaluated from the live digits.
    always_comb begin
        cap_d        = {bus.min1, bus.min0, bus.sec1, bus.sec0,
                        bus.small_sec1, bus.small_sec0};
        legal_d      = digits_legal(cap_d);
        cap_ok_d     = legal_d && (cap_d != '0);
        // Packed BCD compares in the same order as elapsed time.
        beats_best_d = !best_valid_q || (cap_q < best_time_q);
    end

    // Run tracking FSM with registered results.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            last_time_q  <= '0;
            best_time_q  <= '0;
            best_valid_q <= 1'b0;
            new_record_q <= 1'b0;
            bcd_error_q  <= 1'b0;
            run_count_q  <= '0;
            cap_q        <= '0;
            cap_ok_q     <= 1'b0;
        end else begin
            new_record_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (gs_s) state_q <= S_RUN;
                end
                S_RUN: begin
                    if (gs_fall) begin
                        state_q  <= S_CAPT;
                        cap_q    <= cap_d;
                        cap_ok_q <= cap_ok_d;
                        if (cap_ok_d) begin
                            last_time_q <= cap_d;
                            if (run_count_q != '1)
                                run_count_q <= run_count_q + RUN_CNT_W'(1);
                        end else if (!legal_d) begin
                            bcd_error_q <= 1'b1;
                        end
                    end
                end
                S_CAPT: begin
                    state_q <= S_CMP;
                    // A simultaneous clear suppresses the update and the pulse.
                    if (cap_ok_q && beats_best_d && !bus.clear_best) begin
                        best_time_q  <= cap_q;
                        best_valid_q <= 1'b1;
                        new_record_q <= 1'b1;
                    end
                end
                S_CMP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
            if (bus.clear_best) begin
                best_time_q  <= '0;
                best_valid_q <= 1'b0;
            end
        end
    end

    assign bus.last_time  = last_time_q;
    assign bus.best_time  = best_time_q;
    assign bus.best_valid = best_valid_q;
    assign bus.new_record = new_record_q;
    assign bus.bcd_error  = bcd_error_q;
    assign bus.run_count  = run_count_q;
    assign bus.disp_time  = bus.disp_sel ? best_time_q : last_time_q;

endmodule

// File: tb/tb_best_time_keeper.sv
// Directed self-checking bench for best_time_keeper.
`timescale 1ns/1ps
module tb_best_time_keeper;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    best_time_keeper_if #(.RUN_CNT_W(8)) bus ();

    best_time_keeper #(
        .SYNC_STAGES (2),
        .RUN_CNT_W   (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_digits(input logic [23:0] t);
        {bus.min1, bus.min0, bus.sec1, bus.sec0,
         bus.small_sec1, bus.small_sec0} = t;
    endtask

    // Runs the stopwatch, drops game_state with final digits t, and returns
    // just after the second edge following the first low sample (E2).
    // The next edge (E3) loads last_time, the one after (E4) best_time.
    task automatic finish_run(input logic [23:0] t);
        set_digits(24'h000000);
        bus.game_state = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        set_digits(t);
        bus.game_state = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Reset with random inputs.
        rst = 1'b0;
        bus.game_state = 1'($urandom_range(0, 1));
        set_digits(24'($urandom));
        bus.clear_best = 1'($urandom_range(0, 1));
        bus.disp_sel   = 1'($urandom_range(0, 1));
        repeat (3) step();
        check("rst_last",  32'(bus.last_time),  32'h0);
        check("rst_best",  32'(bus.best_time),  32'h0);
        check("rst_valid", 32'(bus.best_valid), 32'h0);
        check("rst_rec",   32'(bus.new_record), 32'h0);
        check("rst_err",   32'(bus.bcd_error),  32'h0);
        check("rst_cnt",   32'(bus.run_count),  32'h0);
        check("rst_disp",  32'(bus.disp_time),  32'h0);

        bus.game_state = 1'b0;
        bus.clear_best = 1'b0;
        bus.disp_sel   = 1'b0;
        set_digits(24'h000000);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) step();
        check("idle_last", 32'(bus.last_time), 32'h0);
        check("idle_cnt",  32'(bus.run_count), 32'h0);

        // First run 01:23.45.
        finish_run(24'h012345);
        check("r1_last_pre", 32'(bus.last_time), 32'h0);
        step();
        check("r1_last", 32'(bus.last_time),  32'h012345);
        check("r1_cnt",  32'(bus.run_count),  32'd1);
        check("r1_rec0", 32'(bus.new_record), 32'h0);
        check("r1_val0", 32'(bus.best_valid), 32'h0);
        step();
        check("r1_best", 32'(bus.best_time),  32'h012345);
        check("r1_val",  32'(bus.best_valid), 32'h1);
        check("r1_rec",  32'(bus.new_record), 32'h1);
        step();
        check("r1_rec_end", 32'(bus.new_record), 32'h0);

        // Slower run 02:00.00.
        finish_run(24'h020000);
        step();
        check("r2_last", 32'(bus.last_time), 32'h020000);
        check("r2_cnt",  32'(bus.run_count), 32'd2);
        step();
        check("r2_best", 32'(bus.best_time),  32'h012345);
        check("r2_rec",  32'(bus.new_record), 32'h0);
        bus.disp_sel = 1'b0;
        #1;
        check("disp_last", 32'(bus.disp_time), 32'h020000);
        bus.disp_sel = 1'b1;
        #1;
        check("disp_best", 32'(bus.disp_time), 32'h012345);
        step();

        // Faster run 00:59.99.
        finish_run(24'h005999);
        step();
        check("r3_cnt", 32'(bus.run_count), 32'd3);
        step();
        check("r3_best", 32'(bus.best_time),  32'h005999);
        check("r3_rec",  32'(bus.new_record), 32'h1);
        check("r3_disp", 32'(bus.disp_time),  32'h005999);
        step();

        // Equal time does not replace the best.
        finish_run(24'h005999);
        step();
        check("r4_cnt", 32'(bus.run_count), 32'd4);
        step();
        check("r4_best", 32'(bus.best_time),  32'h005999);
        check("r4_rec",  32'(bus.new_record), 32'h0);
        step();

        // Clear on the same edge as the best update: clear wins.
        finish_run(24'h001000);
        step();
        check("r5_last", 32'(bus.last_time), 32'h001000);
        check("r5_cnt",  32'(bus.run_count), 32'd5);
        bus.clear_best = 1'b1;
        step();
        bus.clear_best = 1'b0;
        check("r5_best", 32'(bus.best_time),  32'h0);
        check("r5_val",  32'(bus.best_valid), 32'h0);
        check("r5_rec",  32'(bus.new_record), 32'h0);
        step();

        // Zero time is ignored without flagging an error.
        finish_run(24'h000000);
        step();
        check("zero_last", 32'(bus.last_time), 32'h001000);
        check("zero_cnt",  32'(bus.run_count), 32'd5);
        check("zero_err",  32'(bus.bcd_error), 32'h0);
        step();
        check("zero_val", 32'(bus.best_valid), 32'h0);
        check("zero_rec", 32'(bus.new_record), 32'h0);
        step();

        // sec1 = 6 is illegal.
        finish_run(24'h006000);
        step();
        check("bad_err",  32'(bus.bcd_error), 32'h1);
        check("bad_last", 32'(bus.last_time), 32'h001000);
        check("bad_cnt",  32'(bus.run_count), 32'd5);
        step();
        check("bad_val", 32'(bus.best_valid), 32'h0);
        step();

        // Drive the run counter to saturation with 250 valid runs.
        for (int i = 0; i < 250; i++) begin
            finish_run(24'h030000);
            repeat (3) step();
        end
        check("sat_cnt",  32'(bus.run_count), 32'd255);
        check("sat_best", 32'(bus.best_time), 32'h030000);
        check("sat_err",  32'(bus.bcd_error), 32'h1);
        finish_run(24'h040000);
        step();
        check("sat_hold", 32'(bus.run_count), 32'd255);
        check("sat_last", 32'(bus.last_time), 32'h040000);
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
